// File: rtl/sync_fifo_ctrl.sv
// Parametrised synchronous FIFO with occupancy count, programmable almost-full/empty,
// sticky overflow/underflow flags, synchronous flush and FWFT or registered-read output.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned FWFT         = 1,
    parameter int unsigned AFULL_LEVEL  = FIFO_DEPTH - 2,
    parameter int unsigned AEMPTY_LEVEL = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               flush_i,
    input  logic                               clear_err_i,
    input  logic                               write_i,
    input  logic [DATA_WIDTH-1:0]              wr_data_i,
    input  logic                               read_i,
    output logic [DATA_WIDTH-1:0]              rd_data_o,
    output logic                               rd_valid_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o,
    output logic                               full_o,
    output logic                               empty_o,
    output logic                               almost_full_o,
    output logic                               almost_empty_o,
    output logic                               overflow_o,
    output logic                               underflow_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [PTR_W-1:0]      w_wr_ptr_next;
    logic [PTR_W-1:0]      w_rd_ptr_next;
    logic [CNT_W-1:0]      w_count_next;

    // Acceptance: a write to a full FIFO is allowed only when a read frees the head slot
    always_comb begin
        w_rd_acc      = read_i & (r_count != '0);
        w_wr_acc      = write_i & ((r_count != CNT_FULL) | w_rd_acc);
        w_wr_ptr_next = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
        w_rd_ptr_next = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
        w_count_next  = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= w_wr_ptr_next;
            if (w_rd_acc) r_rd_ptr <= w_rd_ptr_next;
            r_count <= w_count_next;
            // Setting an error wins over clearing it in the same cycle
            if (write_i && !w_wr_acc) r_overflow <= 1'b1;
            else if (clear_err_i)     r_overflow <= 1'b0;
            if (read_i && !w_rd_acc)  r_underflow <= 1'b1;
            else if (clear_err_i)     r_underflow <= 1'b0;
        end
    end

    // Storage is not reset; writes are suppressed during reset and flush
    always_ff @(posedge clk_i) begin
        if (rst_n_i && !flush_i && w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data_o  = r_mem[r_rd_ptr];
            assign rd_valid_o = (r_count != '0);
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rd_data;
            logic                  r_rd_valid;

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (flush_i) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
                end
            end

            assign rd_data_o  = r_rd_data;
            assign rd_valid_o = r_rd_valid;
        end
    endgenerate

    assign count_o        = r_count;
    assign full_o         = (r_count == CNT_FULL);
    assign empty_o        = (r_count == '0);
    assign almost_full_o  = (r_count >= CNT_W'(AFULL_LEVEL));
    assign almost_empty_o = (r_count <= CNT_W'(AEMPTY_LEVEL));
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: a depth-5 FWFT instance and a depth-16 registered-read
// instance, with expected read data held in per-instance scoreboard queues.
module tb_sync_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH=5, FWFT=1
    logic       a_rst_n, a_flush, a_clr, a_wr, a_rd;
    logic [7:0] a_wd, a_rdata;
    logic       a_rvalid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [2:0] a_count;

    // Instance B: DEPTH=16, FWFT=0, AFULL=14, AEMPTY=2
    logic       b_rst_n, b_flush, b_clr, b_wr, b_rd;
    logic [7:0] b_wd, b_rdata;
    logic       b_rvalid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [4:0] b_count;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(1)) dut_a (
        .clk_i(clk), .rst_n_i(a_rst_n), .flush_i(a_flush), .clear_err_i(a_clr),
        .write_i(a_wr), .wr_data_i(a_wd), .read_i(a_rd), .rd_data_o(a_rdata),
        .rd_valid_o(a_rvalid), .count_o(a_count), .full_o(a_full), .empty_o(a_empty),
        .almost_full_o(a_af), .almost_empty_o(a_ae), .overflow_o(a_ovf), .underflow_o(a_udf)
    );

    sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(0),
                     .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) dut_b (
        .clk_i(clk), .rst_n_i(b_rst_n), .flush_i(b_flush), .clear_err_i(b_clr),
        .write_i(b_wr), .wr_data_i(b_wd), .read_i(b_rd), .rd_data_o(b_rdata),
        .rd_valid_o(b_rvalid), .count_o(b_count), .full_o(b_full), .empty_o(b_empty),
        .almost_full_o(b_af), .almost_empty_o(b_ae), .overflow_o(b_ovf), .underflow_o(b_udf)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    int         mcnt    = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] exp_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic a_cyc(input logic wr, input logic [7:0] d, input logic rd);
        a_wr = wr; a_wd = d; a_rd = rd;
        @(posedge clk); #1;
        a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic b_cyc(input logic rst_n, input logic flush, input logic clr,
                         input logic wr, input logic [7:0] d, input logic rd);
        b_rst_n = rst_n; b_flush = flush; b_clr = clr; b_wr = wr; b_wd = d; b_rd = rd;
        @(posedge clk); #1;
        b_rst_n = 1'b1; b_flush = 1'b0; b_clr = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
    endtask

    task automatic b_status(input string tag, input int c);
        chk({tag, ".count"}, 32'(b_count), 32'(c));
        chk({tag, ".empty"}, 32'(b_empty), 32'(c == 0));
        chk({tag, ".full"},  32'(b_full),  32'(c == 16));
        chk({tag, ".aempty"}, 32'(b_ae),   32'(c <= 2));
        chk({tag, ".afull"},  32'(b_af),   32'(c >= 14));
    endtask

    initial begin
        a_rst_n = 1'b0; a_flush = 1'b0; a_clr = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_wd = '0;
        b_rst_n = 1'b0; b_flush = 1'b0; b_clr = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_wd = '0;
        @(posedge clk); @(posedge clk); #1;
        a_rst_n = 1'b1; b_rst_n = 1'b1;

        // Reset state of both instances
        chk("a_rst.count", 32'(a_count), 32'(0));
        chk("a_rst.empty", 32'(a_empty), 32'(1));
        chk("a_rst.full",  32'(a_full),  32'(0));
        chk("a_rst.ae",    32'(a_ae),    32'(1));
        chk("a_rst.af",    32'(a_af),    32'(0));
        chk("a_rst.valid", 32'(a_rvalid), 32'(0));
        chk("a_rst.ovf",   32'(a_ovf),   32'(0));
        chk("a_rst.udf",   32'(a_udf),   32'(0));
        b_status("b_rst", 0);
        chk("b_rst.rdata", 32'(b_rdata), 32'(0));
        chk("b_rst.valid", 32'(b_rvalid), 32'(0));

        // Fill depth-5 FIFO, then overflow it
        for (int i = 0; i < 5; i++) begin
            a_cyc(1'b1, 8'h11 + 8'(i), 1'b0);
            qa.push_back(8'h11 + 8'(i));
            chk($sformatf("a_fill%0d.count", i), 32'(a_count), 32'(i + 1));
        end
        chk("a_fill.full", 32'(a_full), 32'(1));
        a_cyc(1'b1, 8'h16, 1'b0);
        chk("a_ovf.flag",  32'(a_ovf),   32'(1));
        chk("a_ovf.count", 32'(a_count), 32'(5));

        // Simultaneous read+write while full, then drain across the pointer wrap
        a_wr = 1'b1; a_wd = 8'hA0; a_rd = 1'b1;
        exp_d = qa.pop_front();
        chk("a_rw.valid", 32'(a_rvalid), 32'(1));
        chk("a_rw.rdata", 32'(a_rdata), 32'(exp_d));
        qa.push_back(8'hA0);
        @(posedge clk); #1;
        a_wr = 1'b0; a_rd = 1'b0;
        chk("a_rw.count", 32'(a_count), 32'(5));
        chk("a_rw.full",  32'(a_full),  32'(1));
        for (int i = 0; i < 5; i++) begin
            a_rd = 1'b1;
            exp_d = qa.pop_front();
            chk($sformatf("a_drain%0d.rdata", i), 32'(a_rdata), 32'(exp_d));
            @(posedge clk); #1;
            a_rd = 1'b0;
            chk($sformatf("a_drain%0d.count", i), 32'(a_count), 32'(4 - i));
        end
        chk("a_drain.empty", 32'(a_empty), 32'(1));
        chk("a_drain.valid", 32'(a_rvalid), 32'(0));

        // Registered read latency, underflow with data hold, error clear
        b_cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
        qb.push_back(8'h5A);
        chk("b_wr.valid", 32'(b_rvalid), 32'(0));
        b_cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("b_rd.valid", 32'(b_rvalid), 32'(1));
        if (b_rvalid) begin
            exp_d = qb.pop_front();
            chk("b_rd.rdata", 32'(b_rdata), 32'(exp_d));
        end
        b_cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("b_udf.flag",  32'(b_udf),    32'(1));
        chk("b_udf.valid", 32'(b_rvalid), 32'(0));
        chk("b_udf.rdata", 32'(b_rdata),  32'(8'h5A));
        b_cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("b_clr.udf", 32'(b_udf), 32'(0));

        // Threshold flags across a full fill, overflow, and full drain
        mcnt = 0;
        for (int i = 0; i < 16; i++) begin
            b_cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h80 + 8'(i), 1'b0);
            qb.push_back(8'h80 + 8'(i));
            mcnt++;
            b_status($sformatf("b_fill%0d", i), mcnt);
        end
        b_cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        chk("b_ovf.flag", 32'(b_ovf), 32'(1));
        b_status("b_ovf", 16);
        for (int i = 0; i < 16; i++) begin
            b_cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            mcnt--;
            chk($sformatf("b_drain%0d.valid", i), 32'(b_rvalid), 32'(1));
            exp_d = qb.pop_front();
            chk($sformatf("b_drain%0d.rdata", i), 32'(b_rdata), 32'(exp_d));
            b_status($sformatf("b_drain%0d", i), mcnt);
        end
        for (int i = 0; i < 7; i++) begin
            b_cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h40 + 8'(i), 1'b0);
            qb.push_back(8'h40 + 8'(i));
            mcnt++;
        end
        b_status("b_seven", 7);
        chk("b_seven.ovf", 32'(b_ovf), 32'(1));

        // Flush with simultaneous requests
        b_cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h99, 1'b1);
        qb.delete();
        mcnt = 0;
        b_status("b_flush", 0);
        chk("b_flush.ovf",   32'(b_ovf),    32'(0));
        chk("b_flush.udf",   32'(b_udf),    32'(0));
        chk("b_flush.valid", 32'(b_rvalid), 32'(0));
        b_cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
        qb.push_back(8'h33);
        b_cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("b_post_flush.valid", 32'(b_rvalid), 32'(1));
        exp_d = qb.pop_front();
        chk("b_post_flush.rdata", 32'(b_rdata), 32'(exp_d));

        // Mid-stream reset with 9 words queued
        for (int i = 0; i < 9; i++) begin
            b_cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
            qb.push_back(8'hC0 + 8'(i));
        end
        b_status("b_nine", 9);
        b_cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
        qb.delete();
        b_status("b_mrst", 0);
        chk("b_mrst.rdata", 32'(b_rdata),  32'(0));
        chk("b_mrst.valid", 32'(b_rvalid), 32'(0));
        chk("b_mrst.ovf",   32'(b_ovf),    32'(0));
        chk("b_mrst.udf",   32'(b_udf),    32'(0));
        b_cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("b_post_rst.udf",   32'(b_udf),    32'(1));
        chk("b_post_rst.valid", 32'(b_rvalid), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
